// File: rtl/fighter_engine_if.sv
// Bundle of frame pulse, player controls and game-state outputs exchanged
// between the board/sync side and the fighter game-logic core.
interface fighter_engine_if #(
  parameter int COORD_W = 11
);
  logic                      frame_tick;
  logic [2:0]                p1_ctrl;
  logic                      p1_kick;
  logic [2:0]                p2_ctrl;
  logic                      p2_kick;
  logic signed [COORD_W-1:0] p1_x;
  logic signed [COORD_W-1:0] p1_y;
  logic signed [COORD_W-1:0] p2_x;
  logic signed [COORD_W-1:0] p2_y;
  logic signed [COORD_W-1:0] p1_health;
  logic signed [COORD_W-1:0] p2_health;
  logic                      p1_kick_on;
  logic                      p2_kick_on;
  logic [1:0]                game_state;
  logic [1:0]                winner;

  // Board / sync side: drives controls, observes game state.
  modport master (
    output frame_tick, p1_ctrl, p1_kick, p2_ctrl, p2_kick,
    input  p1_x, p1_y, p2_x, p2_y, p1_health, p2_health,
    input  p1_kick_on, p2_kick_on, game_state, winner
  );

  // Game core side.
  modport slave (
    input  frame_tick, p1_ctrl, p1_kick, p2_ctrl, p2_kick,
    output p1_x, p1_y, p2_x, p2_y, p1_health, p2_health,
    output p1_kick_on, p2_kick_on, game_state, winner
  );
endinterface

// File: rtl/fighter_engine.sv
// Two-player fighting-game logic core. All gameplay state advances once per
// video frame on frame_tick: movement with screen clamping, per-player kick
// state machines, box-overlap hit detection, saturating health and a
// PLAY/KO/RESTART game state machine. Player 0 is P1, player 1 is P2.
module fighter_engine #(
  parameter int COORD_W         = 11,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int PW              = 100,
  parameter int PH              = 200,
  parameter int KW              = 100,
  parameter int KH              = 20,
  parameter int P1_X0           = 300,
  parameter int P2_X0           = 400,
  parameter int Y0              = 100,
  parameter int HEALTH_MAX      = 300,
  parameter int DAMAGE          = 100,
  parameter int JUMP_DY         = 5,
  parameter int GRAVITY         = 1,
  parameter int KICK_FRAMES     = 8,
  parameter int COOLDOWN_FRAMES = 16,
  parameter int KO_FRAMES       = 120
) (
  input  logic            clk,
  input  logic            rst_n,
  fighter_engine_if.slave bus
);

  // Two guard bits so box edges (x+PW+KW, x-KW) never wrap.
  typedef logic signed [COORD_W+1:0] wide_t;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    K_IDLE   = 2'd0,
    K_ACTIVE = 2'd1,
    K_COOL   = 2'd2
  } kick_state_t;

  typedef enum logic [1:0] {
    G_PLAY    = 2'd0,
    G_KO      = 2'd1,
    G_RESTART = 2'd2
  } game_state_t;

  localparam int KMAX   = (KICK_FRAMES > COOLDOWN_FRAMES) ? KICK_FRAMES : COOLDOWN_FRAMES;
  localparam int KCNT_W = $clog2(KMAX + 1);
  localparam int KO_W   = $clog2(KO_FRAMES + 1);

  localparam logic [KCNT_W-1:0] KICK_LAST = KCNT_W'(KICK_FRAMES - 1);
  localparam logic [KCNT_W-1:0] COOL_LAST = KCNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [KCNT_W-1:0] KCNT_ZERO = {KCNT_W{1'b0}};
  localparam logic [KO_W-1:0]   KO_LAST   = KO_W'(KO_FRAMES - 1);
  localparam logic [KO_W-1:0]   KO_ZERO   = {KO_W{1'b0}};

  localparam coord_t P1_X0_C    = coord_t'(P1_X0);
  localparam coord_t P2_X0_C    = coord_t'(P2_X0);
  localparam coord_t Y0_C       = coord_t'(Y0);
  localparam coord_t HEALTH_C   = coord_t'(HEALTH_MAX);
  localparam coord_t COORD_ZERO = {COORD_W{1'b0}};

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // Horizontal step for a control word.
  function automatic wide_t dx_of(input logic [2:0] ctrl);
    case (ctrl)
      3'b001:  dx_of = wide_t'(1);
      3'b010:  dx_of = wide_t'(-1);
      default: dx_of = wide_t'(0);
    endcase
  endfunction

  // Vertical step for a control word: jump up while held, else fall.
  function automatic wide_t dy_of(input logic [2:0] ctrl);
    case (ctrl)
      3'b100:  dy_of = wide_t'(-JUMP_DY);
      default: dy_of = wide_t'(GRAVITY);
    endcase
  endfunction

  // One-axis move that holds the axis if the box would leave the screen.
  function automatic coord_t step_axis(input wide_t pos, input wide_t delta,
                                       input int extent, input int limit);
    wide_t nxt;
    nxt = pos + delta;
    if ((nxt > wide_t'(0)) && ((nxt + wide_t'(extent)) < wide_t'(limit))) begin
      return nxt[COORD_W-1:0];
    end else begin
      return pos[COORD_W-1:0];
    end
  endfunction

  // Half-open overlap of a kick box with the opponent body box.
  function automatic logic box_hit(input wide_t kx0, input wide_t kx1,
                                   input wide_t ky0, input wide_t ky1,
                                   input coord_t ox, input coord_t oy);
    wide_t bx0, bx1, by0, by1;
    bx0 = wide_t'(ox);
    bx1 = bx0 + wide_t'(PW);
    by0 = wide_t'(oy);
    by1 = by0 + wide_t'(PH);
    return (kx0 < bx1) && (bx0 < kx1) && (ky0 < by1) && (by0 < ky1);
  endfunction

  // Health minus one hit, floored at zero.
  function automatic coord_t sat_sub(input coord_t h);
    wide_t d;
    d = wide_t'(h) - wide_t'(DAMAGE);
    if (d <= wide_t'(0)) begin
      return COORD_ZERO;
    end else begin
      return d[COORD_W-1:0];
    end
  endfunction

  // State registers
  coord_t            x_r        [2];
  coord_t            y_r        [2];
  coord_t            health_r   [2];
  kick_state_t       kstate_r   [2];
  logic [KCNT_W-1:0] kcnt_r     [2];
  logic              armed_r    [2];
  logic              hit_done_r [2];
  logic              kick_on_r  [2];
  game_state_t       game_r;
  logic [1:0]        winner_r;
  logic [KO_W-1:0]   ko_cnt_r;

  // Combinational next-state signals
  logic [2:0]        ctrl_s          [2];
  logic              kick_s          [2];
  coord_t            x_next_s        [2];
  coord_t            y_next_s        [2];
  coord_t            health_next_s   [2];
  wide_t             kx0_s           [2];
  wide_t             kx1_s           [2];
  wide_t             ky0_s           [2];
  wide_t             ky1_s           [2];
  logic              hit_s           [2];
  kick_state_t       kstate_next_s   [2];
  logic [KCNT_W-1:0] kcnt_next_s     [2];
  logic              armed_next_s    [2];
  logic              hit_done_next_s [2];
  logic              ko_s;
  logic [1:0]        winner_next_s;

  assign ctrl_s[0] = bus.p1_ctrl;
  assign ctrl_s[1] = bus.p2_ctrl;
  assign kick_s[0] = bus.p1_kick;
  assign kick_s[1] = bus.p2_kick;

  // Movement, kick boxes from pre-move positions, hits, damage and KO detect.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      x_next_s[i] = step_axis(wide_t'(x_r[i]), dx_of(ctrl_s[i]), PW, SCREEN_W);
      y_next_s[i] = step_axis(wide_t'(y_r[i]), dy_of(ctrl_s[i]), PH, SCREEN_H);
      ky0_s[i]    = wide_t'(y_r[i]) + wide_t'(PH - KH);
      ky1_s[i]    = wide_t'(y_r[i]) + wide_t'(PH);
    end
    // P1 kicks to the right of its body, P2 to the left.
    kx0_s[0] = wide_t'(x_r[0]) + wide_t'(PW);
    kx1_s[0] = kx0_s[0] + wide_t'(KW);
    kx0_s[1] = wide_t'(x_r[1]) - wide_t'(KW);
    kx1_s[1] = wide_t'(x_r[1]);

    hit_s[0] = (game_r == G_PLAY) && (kstate_r[0] == K_ACTIVE) && !hit_done_r[0] &&
               box_hit(kx0_s[0], kx1_s[0], ky0_s[0], ky1_s[0], x_r[1], y_r[1]);
    hit_s[1] = (game_r == G_PLAY) && (kstate_r[1] == K_ACTIVE) && !hit_done_r[1] &&
               box_hit(kx0_s[1], kx1_s[1], ky0_s[1], ky1_s[1], x_r[0], y_r[0]);

    // A player's health drops when the opponent lands a hit.
    health_next_s[0] = hit_s[1] ? sat_sub(health_r[0]) : health_r[0];
    health_next_s[1] = hit_s[0] ? sat_sub(health_r[1]) : health_r[1];

    ko_s = (health_next_s[0] == COORD_ZERO) || (health_next_s[1] == COORD_ZERO);
    if ((health_next_s[0] == COORD_ZERO) && (health_next_s[1] == COORD_ZERO)) begin
      winner_next_s = WIN_DRAW;
    end else if (health_next_s[1] == COORD_ZERO) begin
      winner_next_s = WIN_P1;
    end else if (health_next_s[0] == COORD_ZERO) begin
      winner_next_s = WIN_P2;
    end else begin
      winner_next_s = WIN_NONE;
    end
  end

  // Per-player kick state machine next state; a release re-arms the kick.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      kstate_next_s[i]   = kstate_r[i];
      kcnt_next_s[i]     = kcnt_r[i];
      armed_next_s[i]    = kick_s[i] ? armed_r[i] : 1'b1;
      hit_done_next_s[i] = hit_done_r[i];
      case (kstate_r[i])
        K_IDLE: begin
          if (kick_s[i] && armed_r[i]) begin
            kstate_next_s[i]   = K_ACTIVE;
            kcnt_next_s[i]     = KCNT_ZERO;
            armed_next_s[i]    = 1'b0;
            hit_done_next_s[i] = 1'b0;
          end else begin
            kstate_next_s[i] = K_IDLE;
          end
        end
        K_ACTIVE: begin
          hit_done_next_s[i] = hit_done_r[i] | hit_s[i];
          if (kcnt_r[i] == KICK_LAST) begin
            kstate_next_s[i] = K_COOL;
            kcnt_next_s[i]   = KCNT_ZERO;
          end else begin
            kcnt_next_s[i] = kcnt_r[i] + KCNT_W'(1);
          end
        end
        K_COOL: begin
          if (kcnt_r[i] == COOL_LAST) begin
            kstate_next_s[i] = K_IDLE;
            kcnt_next_s[i]   = KCNT_ZERO;
          end else begin
            kcnt_next_s[i] = kcnt_r[i] + KCNT_W'(1);
          end
        end
        default: begin
          kstate_next_s[i] = K_IDLE;
          kcnt_next_s[i]   = KCNT_ZERO;
        end
      endcase
    end
  end

  // Game state machine and all frame-rate state; holds between frame ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r[0] <= P1_X0_C;
      x_r[1] <= P2_X0_C;
      for (int i = 0; i < 2; i++) begin
        y_r[i]        <= Y0_C;
        health_r[i]   <= HEALTH_C;
        kstate_r[i]   <= K_IDLE;
        kcnt_r[i]     <= KCNT_ZERO;
        armed_r[i]    <= 1'b0;
        hit_done_r[i] <= 1'b0;
        kick_on_r[i]  <= 1'b0;
      end
      game_r   <= G_PLAY;
      winner_r <= WIN_NONE;
      ko_cnt_r <= KO_ZERO;
    end else if (bus.frame_tick) begin
      case (game_r)
        G_PLAY: begin
          for (int i = 0; i < 2; i++) begin
            x_r[i]      <= x_next_s[i];
            y_r[i]      <= y_next_s[i];
            health_r[i] <= health_next_s[i];
          end
          if (ko_s) begin
            game_r   <= G_KO;
            winner_r <= winner_next_s;
            ko_cnt_r <= KO_ZERO;
            for (int i = 0; i < 2; i++) begin
              kstate_r[i]   <= K_IDLE;
              kcnt_r[i]     <= KCNT_ZERO;
              armed_r[i]    <= 1'b0;
              hit_done_r[i] <= 1'b0;
              kick_on_r[i]  <= 1'b0;
            end
          end else begin
            for (int i = 0; i < 2; i++) begin
              kstate_r[i]   <= kstate_next_s[i];
              kcnt_r[i]     <= kcnt_next_s[i];
              armed_r[i]    <= armed_next_s[i];
              hit_done_r[i] <= hit_done_next_s[i];
              kick_on_r[i]  <= (kstate_next_s[i] == K_ACTIVE);
            end
          end
        end
        G_KO: begin
          // Everything frozen; only the hold counter runs.
          if (ko_cnt_r == KO_LAST) begin
            game_r   <= G_RESTART;
            ko_cnt_r <= KO_ZERO;
          end else begin
            ko_cnt_r <= ko_cnt_r + KO_W'(1);
          end
        end
        G_RESTART: begin
          x_r[0] <= P1_X0_C;
          x_r[1] <= P2_X0_C;
          for (int i = 0; i < 2; i++) begin
            y_r[i]        <= Y0_C;
            health_r[i]   <= HEALTH_C;
            kstate_r[i]   <= K_IDLE;
            kcnt_r[i]     <= KCNT_ZERO;
            armed_r[i]    <= 1'b0;
            hit_done_r[i] <= 1'b0;
            kick_on_r[i]  <= 1'b0;
          end
          game_r   <= G_PLAY;
          winner_r <= WIN_NONE;
          ko_cnt_r <= KO_ZERO;
        end
        default: begin
          game_r <= G_RESTART;
        end
      endcase
    end
  end

  assign bus.p1_x       = x_r[0];
  assign bus.p1_y       = y_r[0];
  assign bus.p2_x       = x_r[1];
  assign bus.p2_y       = y_r[1];
  assign bus.p1_health  = health_r[0];
  assign bus.p2_health  = health_r[1];
  assign bus.p1_kick_on = kick_on_r[0];
  assign bus.p2_kick_on = kick_on_r[1];
  assign bus.game_state = game_r;
  assign bus.winner     = winner_r;

endmodule

// File: tb/tb_fighter_engine.sv
// Directed testbench for fighter_engine: movement and screen clamping, kick
// timing and arming, single hit per kick, KO/restart and async reset.
module tb_fighter_engine;

  logic clk;
  logic rst_n;
  int   check_cnt = 0;
  int   err_cnt   = 0;
  int   on_cnt;

  fighter_engine_if #(.COORD_W(11)) bus ();

  fighter_engine #(.COORD_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic tick_k(input logic k1, input logic k2);
    bus.p1_kick = k1;
    bus.p2_kick = k2;
    tick();
  endtask

  // Release, press, then enough released ticks to return to idle.
  task automatic kick_cycle(input logic k1, input logic k2);
    tick_k(1'b0, 1'b0);
    tick_k(k1, k2);
    repeat (24) tick_k(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0;
    bus.p1_ctrl    = 3'b000;
    bus.p2_ctrl    = 3'b000;
    bus.p1_kick    = 1'b0;
    bus.p2_kick    = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_p1x"}, bus.p1_x, 300);
    check_eq({pfx, "_p1y"}, bus.p1_y, 100);
    check_eq({pfx, "_p2x"}, bus.p2_x, 400);
    check_eq({pfx, "_p2y"}, bus.p2_y, 100);
    check_eq({pfx, "_p1h"}, bus.p1_health, 300);
    check_eq({pfx, "_p2h"}, bus.p2_health, 300);
    check_eq({pfx, "_p1on"}, bus.p1_kick_on, 0);
    check_eq({pfx, "_p2on"}, bus.p2_kick_on, 0);
    check_eq({pfx, "_state"}, bus.game_state, 0);
    check_eq({pfx, "_winner"}, bus.winner, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, walking right, no change without frame_tick
    do_reset();
    check_reset_vals("rst");
    bus.p1_ctrl = 3'b001;
    repeat (10) tick();
    check_eq("t1_p1x", bus.p1_x, 310);
    check_eq("t1_p1y", bus.p1_y, 110);
    repeat (20) @(posedge clk);
    #1;
    check_eq("t1_hold_p1x", bus.p1_x, 310);
    check_eq("t1_hold_p1y", bus.p1_y, 110);
    bus.p1_ctrl = 3'b100;
    repeat (3) tick();
    check_eq("t1_jump_p1y", bus.p1_y, 95);
    check_eq("t1_jump_p1x", bus.p1_x, 310);
    bus.p1_ctrl = 3'b011;
    tick();
    check_eq("t1_both_p1x", bus.p1_x, 310);
    check_eq("t1_both_p1y", bus.p1_y, 96);
    check_eq("t1_p2y", bus.p2_y, 114);

    // Top boundary under jump, other-ctrl code falls
    do_reset();
    bus.p1_ctrl = 3'b100;
    bus.p2_ctrl = 3'b110;
    repeat (25) tick();
    check_eq("top_p1y", bus.p1_y, 5);
    check_eq("other_p2y", bus.p2_y, 125);
    check_eq("other_p2x", bus.p2_x, 400);

    // Left edge and floor
    do_reset();
    bus.p1_ctrl = 3'b010;
    bus.p2_ctrl = 3'b000;
    repeat (295) tick();
    check_eq("t2_p1x_5", bus.p1_x, 5);
    repeat (10) tick();
    check_eq("t2_p1x_left", bus.p1_x, 1);
    check_eq("t2_p1y_floor", bus.p1_y, 279);
    check_eq("t2_p2y_floor", bus.p2_y, 279);
    bus.p1_ctrl = 3'b000;
    bus.p2_ctrl = 3'b001;
    repeat (145) tick();
    check_eq("t2_p2x_right", bus.p2_x, 539);
    check_eq("t2_p1x_still", bus.p1_x, 1);

    // Single-tick kick press: 8 active ticks, one hit
    do_reset();
    tick_k(1'b0, 1'b0);
    tick_k(1'b1, 1'b0);
    check_eq("t3_on_first", bus.p1_kick_on, 1);
    check_eq("t3_p2h_press", bus.p2_health, 300);
    on_cnt = int'(bus.p1_kick_on);
    repeat (12) begin
      tick_k(1'b0, 1'b0);
      on_cnt += int'(bus.p1_kick_on);
    end
    check_eq("t3_on_ticks", on_cnt, 8);
    check_eq("t3_p2h", bus.p2_health, 200);
    check_eq("t3_p1h", bus.p1_health, 300);
    check_eq("t3_p2on", bus.p2_kick_on, 0);

    // Kick held 30 ticks: only one activation
    do_reset();
    tick_k(1'b0, 1'b0);
    on_cnt = 0;
    repeat (30) begin
      tick_k(1'b1, 1'b0);
      on_cnt += int'(bus.p1_kick_on);
    end
    check_eq("t3_held_on_ticks", on_cnt, 8);
    check_eq("t3_held_p2h", bus.p2_health, 200);

    // Re-press during cooldown ignored; accepted 25 ticks after first press
    do_reset();
    tick_k(1'b0, 1'b0);
    tick_k(1'b1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      tick_k((i >= 15) ? 1'b1 : 1'b0, 1'b0);
      check_eq($sformatf("t4_on_%0d", i), bus.p1_kick_on,
               ((i <= 7) || (i >= 25)) ? 1 : 0);
    end
    check_eq("t4_p2h", bus.p2_health, 100);

    // P1 wins by KO, hold, restart
    do_reset();
    kick_cycle(1'b1, 1'b0);
    kick_cycle(1'b1, 1'b0);
    check_eq("t5_p2h_100", bus.p2_health, 100);
    tick_k(1'b0, 1'b0);
    tick_k(1'b1, 1'b0);
    tick_k(1'b0, 1'b0);
    check_eq("t5_p2h_0", bus.p2_health, 0);
    check_eq("t5_p1h", bus.p1_health, 300);
    check_eq("t5_state_ko", bus.game_state, 1);
    check_eq("t5_winner", bus.winner, 1);
    check_eq("t5_on_ko", bus.p1_kick_on, 0);
    bus.p1_ctrl = 3'b001;
    repeat (119) tick_k(1'b1, 1'b1);
    check_eq("t5_still_ko", bus.game_state, 1);
    check_eq("t5_frozen_p1x", bus.p1_x, 300);
    check_eq("t5_frozen_p1y", bus.p1_y, 155);
    check_eq("t5_frozen_p2h", bus.p2_health, 0);
    check_eq("t5_ko_on", bus.p1_kick_on, 0);
    tick();
    check_eq("t5_restart", bus.game_state, 2);
    check_eq("t5_restart_winner", bus.winner, 1);
    tick();
    check_reset_vals("t5_play");
    tick();
    check_eq("t5_move_p1x", bus.p1_x, 301);
    check_eq("t5_unarmed_on", bus.p1_kick_on, 0);

    // Mutual KO draw, async reset mid-KO
    do_reset();
    kick_cycle(1'b1, 1'b1);
    kick_cycle(1'b1, 1'b1);
    check_eq("t6_p1h_100", bus.p1_health, 100);
    check_eq("t6_p2h_100", bus.p2_health, 100);
    tick_k(1'b0, 1'b0);
    tick_k(1'b1, 1'b1);
    tick_k(1'b0, 1'b0);
    check_eq("t6_p1h_0", bus.p1_health, 0);
    check_eq("t6_p2h_0", bus.p2_health, 0);
    check_eq("t6_state_ko", bus.game_state, 1);
    check_eq("t6_winner", bus.winner, 3);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_async");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
